// File: rtl/mux_arb_nto1.sv
// mux_arb_nto1: N-to-1 data multiplexer with a one-word registered output stage.
// In fixed mode the channel is picked by 'sel'. In round-robin mode the first
// requester after the last round-robin winner is picked. Handshake is
// valid/ready on both sides. in_ready is combinational from current state and
// inputs, so a word moves from input to output register in one cycle.
module mux_arb_nto1 #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS*WIDTH-1:0]  in_data,
  input  logic [CHANNELS-1:0]        in_valid,
  output logic [CHANNELS-1:0]        in_ready,
  input  logic                       mode,
  input  logic [SEL_W-1:0]           sel,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_W-1:0]           out_chan,
  output logic                       out_valid,
  input  logic                       out_ready
);

  // Index of the channel that receives first priority after reset, so that
  // the search starting at rr_ptr+1 begins at channel 0.
  localparam logic [SEL_W-1:0] RR_RESET = SEL_W'(CHANNELS - 1);

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Fixed-select request check. A select value that names no existing channel
  // never matches a loop index, so it yields no request.
  function automatic logic fix_pick(
    input logic [CHANNELS-1:0] req,
    input logic [SEL_W-1:0]    s
  );
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (s == SEL_W'(i)) begin
        hit = req[i];
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  // Round-robin pick. The request vector is doubled and shifted so that bit j
  // of 'rot' is the request of channel (ptr+1+j) mod CHANNELS. Scanning j from
  // the top down lets the lowest j (closest to ptr+1) win.
  // Returns {hit, index}.
  function automatic logic [SEL_W:0] rr_pick(
    input logic [CHANNELS-1:0] req,
    input logic [SEL_W-1:0]    ptr
  );
    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    logic                  hit;
    logic [SEL_W-1:0]      idx;
    dbl = {req, req};
    rot = CHANNELS'(dbl >> (int'(ptr) + 1));
    hit = 1'b0;
    idx = {SEL_W{1'b0}};
    for (int j = CHANNELS - 1; j >= 0; j--) begin
      if (rot[j]) begin
        hit = 1'b1;
        idx = SEL_W'((int'(ptr) + 1 + j) % CHANNELS);
      end else begin
        hit = hit;
        idx = idx;
      end
    end
    return {hit, idx};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]    out_data_r;
  logic [SEL_W-1:0]    out_chan_r;
  logic                out_valid_r;
  logic [SEL_W-1:0]    rr_ptr_r;

  // ---------------------------------------------------------------------------
  // Combinational grant path
  // ---------------------------------------------------------------------------
  logic                load_s;
  logic                fix_hit_s;
  logic [SEL_W:0]      rr_res_s;
  logic                grant_valid_s;
  logic [SEL_W-1:0]    grant_idx_s;
  logic [CHANNELS-1:0] in_ready_s;
  logic                xfer_s;
  logic [WIDTH-1:0]    grant_data_s;

  // The output register can take a new word when empty or draining this cycle.
  assign load_s = ~out_valid_r | out_ready;

  // Evaluate both candidate arbiters every cycle; mode only picks between them.
  always_comb begin
    fix_hit_s = fix_pick(in_valid, sel);
    rr_res_s  = rr_pick(in_valid, rr_ptr_r);
  end

  // Choose the active grant according to the current mode.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_idx_s   = {SEL_W{1'b0}};
    case (mode)
      1'b0: begin
        grant_valid_s = fix_hit_s;
        grant_idx_s   = sel;
      end
      1'b1: begin
        grant_valid_s = rr_res_s[SEL_W];
        grant_idx_s   = rr_res_s[SEL_W-1:0];
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_idx_s   = {SEL_W{1'b0}};
      end
    endcase
  end

  // One-hot accept strobe for the granted channel; suppressed during reset
  // and while the output word is stalled.
  always_comb begin
    in_ready_s = {CHANNELS{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst_n && load_s && grant_valid_s && (grant_idx_s == SEL_W'(i))) begin
        in_ready_s[i] = 1'b1;
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  assign xfer_s = |in_ready_s;

  // Data of the granted channel, fed to the output register.
  always_comb begin
    grant_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx_s == SEL_W'(i)) begin
        grant_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_data_s = grant_data_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------

  // Output word register: load on accept, drop valid on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_chan_r  <= {SEL_W{1'b0}};
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_data_r  <= grant_data_s;
      out_chan_r  <= grant_idx_s;
      out_valid_r <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_data_r  <= out_data_r;
      out_chan_r  <= out_chan_r;
      out_valid_r <= 1'b0;
    end else begin
      out_data_r  <= out_data_r;
      out_chan_r  <= out_chan_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer: advances to the winner of round-robin transfers only,
  // so fixed-mode traffic does not disturb fairness.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_r <= RR_RESET;
    end else if (xfer_s && mode) begin
      rr_ptr_r <= grant_idx_s;
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// tb_mux_arb_nto1: directed scenarios plus randomized traffic, all checked
// against a transaction-level reference model of the multiplexer.
module tb_mux_arb_nto1;

  localparam int W = 16;
  localparam int C = 4;
  localparam int S = 2;

  logic           clk;
  logic           rst_n;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_ready;
  logic           mode;
  logic [S-1:0]   sel;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_chan;
  logic           out_valid;
  logic           out_ready;

  mux_arb_nto1 #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: the word held at the output and the last
  // round-robin winner.
  logic        m_valid = 1'b0;
  logic [W-1:0] m_data = '0;
  int          m_chan  = 0;
  int          m_rr    = C - 1;

  localparam logic [C*W-1:0] D0 = 64'h4444_3333_2222_1111;
  localparam logic [C-1:0]   ALL = 4'b1111;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Channel that should be granted, or -1 for none.
  function automatic int ref_grant(input logic [C-1:0] v, input logic md,
                                   input logic [S-1:0] s, input int rr);
    if (!md) begin
      if (int'(s) < C && v[s]) return int'(s);
      return -1;
    end
    for (int k = 1; k <= C; k++) begin
      if (v[(rr + k) % C]) return (rr + k) % C;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs, check in_ready, clock, update model, check outputs.
  task automatic step(input logic rs, input logic [C-1:0] v, input logic [C*W-1:0] d,
                      input logic md, input logic [S-1:0] s, input logic ordy);
    int g;
    logic [C-1:0] exp_rdy;
    @(negedge clk);
    rst_n = rs; in_valid = v; in_data = d; mode = md; sel = s; out_ready = ordy;
    #1;
    g = ref_grant(v, md, s, m_rr);
    exp_rdy = '0;
    if (rs && (!m_valid || ordy) && g >= 0) exp_rdy[g] = 1'b1;
    check_eq("in_ready", 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (!rs) begin
      m_valid = 1'b0; m_data = '0; m_chan = 0; m_rr = C - 1;
    end else if (exp_rdy != '0) begin
      m_valid = 1'b1; m_data = d[g*W +: W]; m_chan = g;
      if (md) m_rr = g;
    end else if (m_valid && ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("out_data", 64'(out_data), 64'(m_data));
    check_eq("out_chan", 64'(out_chan), 64'(m_chan));
  endtask

  initial begin
    logic [C*W-1:0] rd;
    rst_n = 1'b0; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;

    // Reset with all inputs valid: nothing accepted, outputs cleared.
    step(1'b0, ALL, D0, 1'b1, 2'd0, 1'b1);
    step(1'b0, ALL, D0, 1'b0, 2'd1, 1'b1);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_data", 64'(out_data), 64'd0);

    // Fixed select stepping through channels.
    for (int s = 0; s < C; s++) begin
      step(1'b1, ALL, D0, 1'b0, S'(s), 1'b1);
      check_eq("fix_data", 64'(out_data), 64'(16'h1111 * (s + 1)));
      check_eq("fix_chan", 64'(out_chan), 64'(s));
    end

    // Round-robin from reset: 0,1,2,3,0.
    step(1'b0, ALL, D0, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, ALL, D0, 1'b1, 2'd0, 1'b1);
      check_eq("rr_chan", 64'(out_chan), 64'(i % C));
    end

    // Two requesters alternate: 1,3,1,3.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'b1010, D0, 1'b1, 2'd0, 1'b1);
      check_eq("rr2_chan", 64'(out_chan), 64'((i % 2) ? 3 : 1));
    end

    // Back-pressure: word held for three cycles, then replaced without a bubble.
    step(1'b1, ALL, D0, 1'b0, 2'd1, 1'b1);
    check_eq("bp_load", 64'(out_data), 64'h2222);
    for (int i = 0; i < 3; i++) begin
      rd = {$urandom, $urandom};
      step(1'b1, 4'($urandom), rd, 1'($urandom), 2'($urandom), 1'b0);
      check_eq("bp_hold", 64'(out_data), 64'h2222);
      check_eq("bp_hold_v", 64'(out_valid), 64'd1);
    end
    step(1'b1, ALL, D0, 1'b0, 2'd3, 1'b1);
    check_eq("bp_next", 64'(out_data), 64'h4444);

    // Fixed select on an idle channel: no grant, word drains.
    step(1'b1, 4'b1011, D0, 1'b0, 2'd2, 1'b1);
    check_eq("idle_sel", 64'(out_valid), 64'd0);

    // Round-robin mid-stream, reset for one cycle, channel 0 first afterwards.
    step(1'b1, ALL, D0, 1'b1, 2'd0, 1'b1);
    step(1'b1, ALL, D0, 1'b1, 2'd0, 1'b0);
    step(1'b0, ALL, D0, 1'b1, 2'd0, 1'b0);
    check_eq("mid_rst_v", 64'(out_valid), 64'd0);
    check_eq("mid_rst_d", 64'(out_data), 64'd0);
    step(1'b1, ALL, D0, 1'b1, 2'd0, 1'b1);
    check_eq("post_rst_chan", 64'(out_chan), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rd = {$urandom, $urandom};
      step(($urandom % 60) != 0, 4'($urandom), rd, 1'($urandom),
           2'($urandom), ($urandom % 10) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
